// File: rtl/qpacket_tx_pkg.sv
// qpacket_tx_pkg: shared QTable constants, packet type codes and TX FSM state encoding.
// Revision 1.0
`default_nettype none

package qpacket_tx_pkg;

   localparam int          DEF_WORD_WIDTH = 16;
   localparam logic [15:0] DEF_NO_HOP     = 16'hFFFF;

   localparam logic [2:0] PKT_HELLO  = 3'd0;
   localparam logic [2:0] PKT_DATA   = 3'd1;
   localparam logic [2:0] PKT_ACK    = 3'd2;
   localparam logic [2:0] PKT_QUPD   = 3'd3;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_READ = 3'd1,
      S_WAIT = 3'd2,
      S_CMP  = 3'd3,
      S_SEND = 3'd4,
      S_DONE = 3'd5
   } state_t;

endpackage

`default_nettype wire

// File: rtl/qpacket_tx_qmax.sv
// qmax_tracker: running maximum Q-value and the neighbor ID that produced it.
// Revision 1.0
`default_nettype none

module qmax_tracker
   import qpacket_tx_pkg::*;
#(
   parameter int                    WORD_WIDTH = DEF_WORD_WIDTH,
   parameter logic [WORD_WIDTH-1:0] NO_HOP     = DEF_NO_HOP
) (
   input  logic                  clock,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  update,
   input  logic                  first,
   input  logic [WORD_WIDTH-1:0] cand_q,
   input  logic [WORD_WIDTH-1:0] cand_id,
   output logic [WORD_WIDTH-1:0] best_q,
   output logic [WORD_WIDTH-1:0] best_id,
   output logic [WORD_WIDTH-1:0] best_q_nxt,
   output logic [WORD_WIDTH-1:0] best_id_nxt
);

   logic take;

   // Strict compare: on a tie the earlier (lower index) entry stays the winner.
   always_comb begin
      take        = update && (first || (cand_q > best_q));
      best_q_nxt  = best_q;
      best_id_nxt = best_id;
      if (clear) begin
         best_q_nxt  = '0;
         best_id_nxt = NO_HOP;
      end else if (take) begin
         best_q_nxt  = cand_q;
         best_id_nxt = cand_id;
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         best_q  <= '0;
         best_id <= NO_HOP;
      end else begin
         best_q  <= best_q_nxt;
         best_id <= best_id_nxt;
      end
   end

endmodule

`default_nettype wire

// File: rtl/qpacket_tx.sv
// qpacket_tx: scans the neighbor table for the best Q-value and transmits one packet.
// Revision 1.0
`default_nettype none

module qpacket_tx
   import qpacket_tx_pkg::*;
#(
   parameter int                    WORD_WIDTH = DEF_WORD_WIDTH,
   parameter logic [WORD_WIDTH-1:0] NO_HOP     = DEF_NO_HOP
) (
   input  logic                  clock,
   input  logic                  rst,
   input  logic                  en,
   input  logic [2:0]            pktType,
   input  logic [WORD_WIDTH-1:0] myNodeID,
   input  logic [WORD_WIDTH-1:0] myClusterID,
   input  logic [WORD_WIDTH-1:0] myEnergy,
   input  logic [WORD_WIDTH-1:0] mNeighborCount,
   output logic                  rd_en,
   output logic [WORD_WIDTH-1:0] rd_index,
   input  logic [WORD_WIDTH-1:0] mSourceID,
   input  logic [WORD_WIDTH-1:0] mQValue,
   output logic [WORD_WIDTH-1:0] fSourceID,
   output logic [WORD_WIDTH-1:0] fClusterID,
   output logic [WORD_WIDTH-1:0] fEnergyLeft,
   output logic [WORD_WIDTH-1:0] fQValue,
   output logic [WORD_WIDTH-1:0] fNextHop,
   output logic [2:0]            fPacketType,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  busy,
   output logic                  done
);

   state_t                  state, next_state;
   logic [WORD_WIDTH-1:0]   idx, idx_next, count;
   logic [WORD_WIDTH-1:0]   lat_node, lat_cluster, lat_energy;
   logic [2:0]              lat_type;
   logic [WORD_WIDTH-1:0]   cap_q, cap_id;
   logic [WORD_WIDTH-1:0]   best_q, best_id, best_q_nxt, best_id_nxt;
   logic                    start, last, load_fields;

   assign idx_next    = idx + 1'b1;
   assign last        = (idx_next == count);
   assign start       = (state == S_IDLE) && en;
   assign load_fields = (next_state == S_SEND) && (state != S_SEND);

   qmax_tracker #(
      .WORD_WIDTH (WORD_WIDTH),
      .NO_HOP     (NO_HOP)
   ) u_qmax (
      .clock       (clock),
      .rst         (rst),
      .clear       (start),
      .update      (state == S_CMP),
      .first       (idx == '0),
      .cand_q      (cap_q),
      .cand_id     (cap_id),
      .best_q      (best_q),
      .best_id     (best_id),
      .best_q_nxt  (best_q_nxt),
      .best_id_nxt (best_id_nxt)
   );

   always_comb begin
      next_state = state;
      rd_en      = 1'b0;
      tx_valid   = 1'b0;
      done       = 1'b0;
      busy       = (state != S_IDLE);
      case (state)
         S_IDLE: if (en) next_state = (mNeighborCount == '0) ? S_SEND : S_READ;
         S_READ: begin
            rd_en      = 1'b1;
            next_state = S_WAIT;
         end
         S_WAIT: next_state = S_CMP;
         S_CMP:  next_state = last ? S_SEND : S_READ;
         S_SEND: begin
            tx_valid = 1'b1;
            if (tx_ready) next_state = S_DONE;
         end
         S_DONE: begin
            done       = 1'b1;
            next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   assign rd_index = idx;

   always_ff @(posedge clock) begin
      if (rst) begin
         state       <= S_IDLE;
         idx         <= '0;
         count       <= '0;
         lat_type    <= '0;
         lat_node    <= '0;
         lat_cluster <= '0;
         lat_energy  <= '0;
         cap_q       <= '0;
         cap_id      <= '0;
         fPacketType <= '0;
         fSourceID   <= '0;
         fClusterID  <= '0;
         fEnergyLeft <= '0;
         fQValue     <= '0;
         fNextHop    <= '0;
      end else begin
         state <= next_state;
         if (start) begin
            idx         <= '0;
            count       <= mNeighborCount;
            lat_type    <= pktType;
            lat_node    <= myNodeID;
            lat_cluster <= myClusterID;
            lat_energy  <= myEnergy;
         end
         if (state == S_WAIT) begin
            cap_q  <= mQValue;
            cap_id <= mSourceID;
         end
         if ((state == S_CMP) && !last) idx <= idx_next;
         // The empty-table path enters S_SEND straight from S_IDLE, before the latches settle.
         if (load_fields) begin
            fPacketType <= (state == S_IDLE) ? pktType     : lat_type;
            fSourceID   <= (state == S_IDLE) ? myNodeID    : lat_node;
            fClusterID  <= (state == S_IDLE) ? myClusterID : lat_cluster;
            fEnergyLeft <= (state == S_IDLE) ? myEnergy    : lat_energy;
            fQValue     <= best_q_nxt;
            fNextHop    <= best_id_nxt;
         end
      end
   end

endmodule

`default_nettype wire
